instr_fetch_unit: RTL

//  Front-end fetch stage of the single-cycle MIPS core. Owns the PC, fetches words from

---
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage with PC ownership, imem req/ready handshake and
//               next-PC selection (jr / jump / branch / sequential).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic [5:0]       opcode,
    output logic [5:0]       func,
    output logic             instr_valid,
    input  logic             instr_accept,
    input  logic             branch,
    input  logic             bneq,
    input  logic             jump,
    input  logic             jal,
    input  logic             alu_zero,
    input  logic [31:0]      jr_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             addr_err,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [5:0]       c_func_jr = 6'b001000;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic             r_instr_valid;
    logic             r_imem_req;
    logic             r_addr_err;
    logic [CNT_W-1:0] r_retired_cnt;

    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_br_off;
    logic [31:0]      w_next_pc;
    logic             w_is_jr;
    logic             w_unused;

    // jal only steers the link write in the datapath; it never changes next_pc
    assign w_unused   = jal;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_is_jr    = (r_instr[31:26] == 6'b000000) && (r_instr[5:0] == c_func_jr);

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_is_jr) begin
            w_next_pc = {jr_target[31:2], 2'b00};
        end else if (jump) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (branch && (alu_zero ^ bneq)) begin
            w_next_pc = w_pc_plus4 + w_br_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_addr_err    <= 1'b0;
            r_retired_cnt <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (r_imem_req && imem_ready) begin
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= HOLD;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_accept) begin
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                        r_retired_cnt <= r_retired_cnt + c_cnt_one;
                        r_imem_req    <= 1'b1;
                        r_state       <= FETCH;
                        // misaligned jr is flagged, but the aligned target is still taken
                        if (w_is_jr && (jr_target[1:0] != 2'b00)) begin
                            r_addr_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign func        = r_instr[5:0];
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign addr_err    = r_addr_err;
    assign retired_cnt = r_retired_cnt;

endmodule

`default_nettype wire
